// File: rtl/mult_arbiter_pkg.sv
// Shared helpers for the round-robin multiplier front end.
// Index arithmetic used by the arbiter search and pointer update.
package mult_arbiter_pkg;

  localparam int MAX_NREQ = 8;

  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/multiplier_parameterized.sv
// Unsigned combinational multiplier, full 2*BIT-wide product.
// Operands are widened first so nothing is truncated.
module multiplier_parameterized #(
  parameter int BIT = 16
) (
  input  logic [BIT-1:0]   a,
  input  logic [BIT-1:0]   b,
  output logic [2*BIT-1:0] product
);

  logic [2*BIT-1:0] a_w;
  logic [2*BIT-1:0] b_w;

  assign a_w     = (2*BIT)'(a);
  assign b_w     = (2*BIT)'(b);
  assign product = a_w * b_w;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr,
// ptr moves past the winner on each accept strobe.
module rr_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'(wrap_idx(int'(ptr) + k, NREQ));
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= IDW'(wrap_idx(int'(grant_id) + 1, NREQ));
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// NREQ requesters share one multiplier through a round-robin
// arbiter and a two-stage valid/ready pipeline.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter  int BIT  = 16,
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*BIT-1:0] req_a,
  input  logic [NREQ*BIT-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*BIT-1:0]    rsp_product,
  output logic                busy
);

  logic                s1_valid;
  logic [BIT-1:0]      s1_a;
  logic [BIT-1:0]      s1_b;
  logic [IDW-1:0]      s1_id;
  logic                s2_valid;
  logic [2*BIT-1:0]    s2_product;
  logic [IDW-1:0]      s2_id;

  logic                s2_load;
  logic                s1_open;
  logic                accept;
  logic                any;
  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_id;
  logic [BIT-1:0]      sel_a;
  logic [BIT-1:0]      sel_b;
  logic [2*BIT-1:0]    product;

  assign s2_load = s1_valid && (!s2_valid || rsp_ready);
  // rst_n gates s1_open so no grant is shown while in reset
  assign s1_open = rst_n && (!s1_valid || s2_load);
  assign accept  = s1_open && any;

  assign req_ready   = s1_open ? grant : '0;
  assign rsp_valid   = s2_valid;
  assign rsp_id      = s2_id;
  assign rsp_product = s2_product;
  assign busy        = s1_valid || s2_valid;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .accept  (accept),
    .grant   (grant),
    .grant_id(grant_id),
    .any     (any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*BIT +: BIT];
        sel_b = req_b[i*BIT +: BIT];
      end
    end
  end

  multiplier_parameterized #(
    .BIT(BIT)
  ) u_mul (
    .a      (s1_a),
    .b      (s1_b),
    .product(product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= sel_a;
      s1_b     <= sel_b;
      s1_id    <= grant_id;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_product <= '0;
      s2_id      <= '0;
    end else if (s2_load) begin
      s2_valid   <= 1'b1;
      s2_product <= product;
      s2_id      <= s1_id;
    end else if (rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus random traffic
// against a queue-based model of grants and in-order results.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_product;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          id;
    logic [31:0] p;
    int          age;
  } item_t;

  item_t       q[$];
  int          ptr;
  int          got_id[$];
  logic [31:0] got_p[$];

  mult_arbiter #(
    .BIT (16),
    .NREQ(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_product(rsp_product),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a,
                         input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic clear_got();
    got_id.delete();
    got_p.delete();
  endtask

  // One clock of the model: at most two results in flight, a new
  // request fits if fewer than two are held or the head leaves now.
  task automatic step();
    int          n;
    int          win;
    logic        out_v;
    logic        pop;
    logic        can;
    logic        acc;
    logic [3:0]  er;
    logic [31:0] p;
    item_t       it;
    #1;
    n     = q.size();
    out_v = (n > 0) && (q[0].age >= 1);
    pop   = out_v && rsp_ready;
    can   = (n < 2) || (rsp_ready == 1'b1);
    win   = -1;
    for (int k = 0; k < 4; k++) begin
      if (win < 0 && req_valid[(ptr + k) % 4]) win = (ptr + k) % 4;
    end
    acc = can && (win >= 0);
    er  = acc ? 4'(1 << win) : 4'b0000;
    p   = '0;
    if (acc) p = 32'(req_a[win*16 +: 16]) * 32'(req_b[win*16 +: 16]);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(out_v));
    chk("busy", 64'(busy), 64'(n > 0));
    if (out_v) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_product", 64'(rsp_product), 64'(q[0].p));
    end
    @(posedge clk);
    if (pop) begin
      got_id.push_back(q[0].id);
      got_p.push_back(q[0].p);
      void'(q.pop_front());
    end
    foreach (q[j]) q[j].age = q[j].age + 1;
    if (acc) begin
      it.id  = win;
      it.p   = p;
      it.age = 0;
      q.push_back(it);
      ptr = (win + 1) % 4;
    end
    @(negedge clk);
    if (acc) req_valid[win] = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    ptr       = 0;
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rsp_product", 64'(rsp_product), 64'h0);
    chk("rst_rsp_id", 64'(rsp_id), 64'h0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // full contention from ptr 0
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 16'(i + 1), 16'd10);
    repeat (8) step();
    chk("cont_count", 64'(got_id.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_id", 64'(got_id[i]), 64'(i));
      chk("cont_prod", 64'(got_p[i]), 64'((i + 1) * 10));
    end

    // single request from requester 2
    clear_got();
    set_req(2, 16'd3, 16'd5);
    step();
    #1;
    chk("single_lat_valid", 64'(rsp_valid), 64'h0);
    step();
    chk("single_valid", 64'(rsp_valid), 64'h1);
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_prod", 64'(rsp_product), 64'd15);
    drain();

    // max and zero operands
    clear_got();
    set_req(0, 16'hFFFF, 16'hFFFF);
    set_req(1, 16'h0000, 16'h1234);
    repeat (6) step();
    chk("max_prod", 64'(got_p[0]), 64'hFFFE0001);
    chk("zero_prod", 64'(got_p[1]), 64'h0);
    chk("max_id", 64'(got_id[0]), 64'd0);

    // pointer wrap after a grant to 3
    set_req(3, 16'd2, 16'd2);
    step();
    set_req(0, 16'd4, 16'd4);
    set_req(3, 16'd6, 16'd6);
    #1;
    chk("wrap_grant", 64'(req_ready), 64'h1);
    step();
    step();
    drain();

    // backpressure with requests 1 and 3
    clear_got();
    rsp_ready = 1'b0;
    set_req(1, 16'd7, 16'd9);
    set_req(3, 16'd11, 16'd13);
    step();
    step();
    set_req(0, 16'd5, 16'd5);
    repeat (5) begin
      #1;
      chk("bp_req_ready", 64'(req_ready), 64'h0);
      chk("bp_hold_id", 64'(rsp_id), 64'd1);
      chk("bp_hold_prod", 64'(rsp_product), 64'd63);
      step();
    end
    rsp_ready = 1'b1;
    repeat (6) step();
    chk("bp_count", 64'(got_id.size()), 64'd3);
    chk("bp_first_id", 64'(got_id[0]), 64'd1);
    chk("bp_first_prod", 64'(got_p[0]), 64'd63);
    chk("bp_second_id", 64'(got_id[1]), 64'd3);
    chk("bp_second_prod", 64'(got_p[1]), 64'd143);

    // reset with both stages full
    rsp_ready = 1'b0;
    set_req(0, 16'd21, 16'd3);
    set_req(2, 16'd22, 16'd3);
    step();
    step();
    req_valid = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'h0);
    q.delete();
    ptr = 0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_got();
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("mid_rst_no_stale", 64'(got_id.size()), 64'd0);

    // random traffic
    repeat (400) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, rnd_op(), rnd_op());
        else if (req_valid[i] && $urandom_range(0, 19) == 0)
          req_valid[i] = 1'b0;
      end
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
